ledda_cfg_seq: RTL
==================

LEDDA_CFG_SEQ -- requirements
Module: ledda_cfg_seq

Interface
REQ-001 SHALL have parameter CR0_VAL, default 8'h82, meaning LEDDCR0 image (bit7 enable, bits1:0 prescale[9:8]).
REQ-002 SHALL have parameter BR_VAL, default 8'hED, meaning LEDDBR image (prescale[7:0]; 749 for 48 MHz).
REQ-003 SHALL have ports: clk in 1, sole clock; resetn in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid in 1, request offered; req_ready out 1, block idle and accepting.
REQ-005 SHALL have ports: req_pwm_r, req_pwm_g, req_pwm_b in 8 each, duty for LEDDPWRR/G/B.
REQ-006 SHALL have ports: req_on, req_off in 8 each, blink on/off time (LEDDONR/LEDDOFR); req_enable in 1, final LEDDEXE level.
REQ-007 SHALL have ports: ledd_cs, ledd_den, ledd_exe out 1 each; ledd_addr out 4; ledd_dat out 8; ledd_clk out 1. These drive the LEDDA_IP register bus.
REQ-008 SHALL have port: done out 1, single-cycle pulse when programming completes.

Function
REQ-009 ledd_clk SHALL equal clk, combinationally; all other bus outputs SHALL be registered on clk rising edge.
REQ-010 States: IDLE, DISABLE, SETUP, STROBE, ENABLE; req_ready SHALL be 1 only in IDLE.
REQ-011 IDLE with req_valid=1 SHALL capture all req_* fields and go to DISABLE; later changes on req_* SHALL be ignored until the next IDLE.
REQ-012 DISABLE (1 cycle) SHALL drive ledd_exe=0, then go to SETUP with write index 0.
REQ-013 SETUP (1 cycle) SHALL drive ledd_cs=1, ledd_den=0, and ledd_addr/ledd_dat for the current index.
REQ-014 STROBE (1 cycle) SHALL hold addr/dat, drive ledd_cs=1 and ledd_den=1, then go to SETUP with index+1, or to ENABLE after the last index.
REQ-015 Write order (addr:data) SHALL be: 8:CR0_VAL, 9:BR_VAL, A:req_on, B:req_off, [5:breathe_on, 6:breathe_off per REQ-024], 1:pwm_r, 2:pwm_g, 3:pwm_b.
REQ-016 ENABLE (1 cycle) SHALL drive ledd_cs=0, ledd_den=0, ledd_exe=captured req_enable, pulse done=1, and return to IDLE.
REQ-017 Outside SETUP/STROBE, ledd_cs and ledd_den SHALL be 0; ledd_addr and ledd_dat SHALL hold their last value.
REQ-018 ledd_exe SHALL change only in DISABLE and ENABLE.
REQ-019 Accept-to-done latency SHALL be 2N+2 cycles, N = number of writes (7 or 9). With req_valid held high, back-to-back requests SHALL be accepted in the cycle after done.

Reset
REQ-020 resetn=0 SHALL immediately force state IDLE and index 0, and SHALL discard any captured request.
REQ-021 Reset values SHALL be: ledd_cs, ledd_den, ledd_exe, done = 0; ledd_addr = 0; ledd_dat = 0; req_ready = 1.
REQ-022 Reset mid-sequence SHALL leave the LEDDA in a partially-written state; the next accepted request SHALL rewrite all registers.

Configuration
REQ-023 Macro LEDDA_BREATHE_EN SHALL add inputs req_breathe_on and req_breathe_off (8 bits each), which are LEDDBCRR/LEDDBCFR values.
REQ-024 With LEDDA_BREATHE_EN defined, N SHALL be 9 and include writes 5 and 6. Without it, N SHALL be 7, those ports SHALL be absent, and addresses 5/6 SHALL never be driven.

Structure
REQ-025 Package ledda_pkg SHALL hold the state enum, the LEDDA register address constants (CR0=8, BR=9, ONR=A, OFR=B, BCRR=5, BCFR=6, PWRR=1, PWRG=2, PWRB=3), and the write-count constant.
REQ-026 SHALL be a single module with no sub-modules; the index-to-addr/data mapping SHALL be a combinational function inside it.

Verification
REQ-027 Reset, then request pwm 10/20/30, on=4, off=8, enable=1 -> exactly the strobes (8,82)(9,ED)(A,04)(B,08)(1,0A)(2,14)(3,1E); done at cycle 16 after accept; ledd_exe=1.
REQ-028 Same as REQ-027 with LEDDA_BREATHE_EN and breathe 3/5 -> strobes (5,03)(6,05) inserted after B; done at cycle 20.
REQ-029 Change req_* to FF after accept -> all strobed data still equals the captured values.
REQ-030 Assert resetn=0 during the third STROBE -> next cycle all outputs are at reset values and req_ready=1; a new request restarts at addr 8.
REQ-031 Two back-to-back requests (enable 1 then 0) -> ledd_exe is 0 during each DISABLE, ends at 0, and done pulses twice, 16 cycles apart from each accept.
REQ-032 Every cycle, checker SHALL confirm ledd_den=1 only when ledd_cs=1, and addr/dat stable across each SETUP→STROBE pair.

Source files
------------

// File: rtl/ledda_pkg.sv
// Shared types and constants for the LEDDA_IP configuration sequencer.
// Holds the FSM state enum, LEDDA register addresses and the write count.
// Optional feature macro: LEDDA_BREATHE_EN adds the breathe-ramp writes.
package ledda_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISABLE,
        ST_SETUP,
        ST_STROBE,
        ST_ENABLE
    } state_t;

    localparam logic [3:0] ADDR_CR0  = 4'h8;
    localparam logic [3:0] ADDR_BR   = 4'h9;
    localparam logic [3:0] ADDR_ONR  = 4'hA;
    localparam logic [3:0] ADDR_OFR  = 4'hB;
    localparam logic [3:0] ADDR_BCRR = 4'h5;
    localparam logic [3:0] ADDR_BCFR = 4'h6;
    localparam logic [3:0] ADDR_PWRR = 4'h1;
    localparam logic [3:0] ADDR_PWRG = 4'h2;
    localparam logic [3:0] ADDR_PWRB = 4'h3;

`ifdef LEDDA_BREATHE_EN
    localparam int unsigned NWR = 9;
`else
    localparam int unsigned NWR = 7;
`endif

    localparam logic [3:0] LAST_IDX = 4'(NWR - 1);
    // Index of the first PWM duty write; the three duties are consecutive.
    localparam logic [3:0] PWM_IDX  = 4'(NWR - 3);

endpackage

// File: rtl/ledda_cfg_seq.sv
// Programs the LEDDA_IP register bus from one captured request, then pulses done.
// Ports: clk/resetn; req_valid/req_ready handshake with req_pwm_r/g/b,
//   req_on/off, req_enable (plus req_breathe_on/off under LEDDA_BREATHE_EN);
//   ledd_cs/den/exe/addr/dat/clk LEDDA bus; done completion pulse.
module ledda_cfg_seq
    import ledda_pkg::*;
#(
    parameter logic [7:0] CR0_VAL = 8'h82,
    parameter logic [7:0] BR_VAL  = 8'hED
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_pwm_r,
    input  logic [7:0] req_pwm_g,
    input  logic [7:0] req_pwm_b,
    input  logic [7:0] req_on,
    input  logic [7:0] req_off,
    input  logic       req_enable,
`ifdef LEDDA_BREATHE_EN
    input  logic [7:0] req_breathe_on,
    input  logic [7:0] req_breathe_off,
`endif
    output logic       ledd_cs,
    output logic       ledd_den,
    output logic       ledd_exe,
    output logic [3:0] ledd_addr,
    output logic [7:0] ledd_dat,
    output logic       ledd_clk,
    output logic       done
);

    state_t     state, state_n;
    logic [3:0] idx, idx_n;

    logic [7:0] cap_r, cap_g, cap_b, cap_on, cap_off;
    logic       cap_en;
`ifdef LEDDA_BREATHE_EN
    logic [7:0] cap_bon, cap_boff;
`endif

    logic       cs_n, den_n, exe_n, done_n;
    logic [3:0] addr_n;
    logic [7:0] dat_n;

    assign ledd_clk  = clk;
    assign req_ready = (state == ST_IDLE);

    // Write index -> {addr, data} for the LEDDA register image.
    function automatic logic [11:0] wr_map(input logic [3:0] i);
        logic [11:0] m;
        m = {ADDR_CR0, CR0_VAL};
        case (i)
            4'd0:        m = {ADDR_CR0, CR0_VAL};
            4'd1:        m = {ADDR_BR, BR_VAL};
            4'd2:        m = {ADDR_ONR, cap_on};
            4'd3:        m = {ADDR_OFR, cap_off};
`ifdef LEDDA_BREATHE_EN
            4'd4:        m = {ADDR_BCRR, cap_bon};
            4'd5:        m = {ADDR_BCFR, cap_boff};
`endif
            PWM_IDX:     m = {ADDR_PWRR, cap_r};
            PWM_IDX + 1: m = {ADDR_PWRG, cap_g};
            PWM_IDX + 2: m = {ADDR_PWRB, cap_b};
            default:     m = {ADDR_CR0, CR0_VAL};
        endcase
        return m;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        unique case (state)
            ST_IDLE:    if (req_valid) state_n = ST_DISABLE;
            ST_DISABLE: begin
                state_n = ST_SETUP;
                idx_n   = '0;
            end
            ST_SETUP:   state_n = ST_STROBE;
            ST_STROBE: begin
                if (idx == LAST_IDX) begin
                    state_n = ST_ENABLE;
                end else begin
                    state_n = ST_SETUP;
                    idx_n   = idx + 4'd1;
                end
            end
            ST_ENABLE:  state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered bus lines
    // line up with the state they belong to.
    always_comb begin
        cs_n   = 1'b0;
        den_n  = 1'b0;
        exe_n  = ledd_exe;
        done_n = 1'b0;
        addr_n = ledd_addr;
        dat_n  = ledd_dat;
        unique case (state_n)
            ST_DISABLE: exe_n = 1'b0;
            ST_SETUP: begin
                cs_n            = 1'b1;
                {addr_n, dat_n} = wr_map(idx_n);
            end
            ST_STROBE: begin
                cs_n  = 1'b1;
                den_n = 1'b1;
            end
            ST_ENABLE: begin
                exe_n  = cap_en;
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ledd_cs   <= 1'b0;
            ledd_den  <= 1'b0;
            ledd_exe  <= 1'b0;
            ledd_addr <= '0;
            ledd_dat  <= '0;
            done      <= 1'b0;
        end else begin
            ledd_cs   <= cs_n;
            ledd_den  <= den_n;
            ledd_exe  <= exe_n;
            ledd_addr <= addr_n;
            ledd_dat  <= dat_n;
            done      <= done_n;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_r    <= '0;
            cap_g    <= '0;
            cap_b    <= '0;
            cap_on   <= '0;
            cap_off  <= '0;
            cap_en   <= 1'b0;
`ifdef LEDDA_BREATHE_EN
            cap_bon  <= '0;
            cap_boff <= '0;
`endif
        end else if (state == ST_IDLE && req_valid) begin
            cap_r    <= req_pwm_r;
            cap_g    <= req_pwm_g;
            cap_b    <= req_pwm_b;
            cap_on   <= req_on;
            cap_off  <= req_off;
            cap_en   <= req_enable;
`ifdef LEDDA_BREATHE_EN
            cap_bon  <= req_breathe_on;
            cap_boff <= req_breathe_off;
`endif
        end
    end

endmodule
